// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the SPI slave register bridge.
//               - spi_state_t       : frame FSM states
//               - c_rw_bit_from_msb : R/nW bit position, counted from the MSB
//                                     of the command word
//               - sample_on_rise()  : 1 when the sample edge is the rising
//                                     edge of sclk for a given CPOL/CPHA
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_t;

    // The R/nW flag is the most significant bit of the command word.
    localparam int c_rw_bit_from_msb = 0;

    // Leading edge is rising for CPOL=0, falling for CPOL=1. CPHA=0 samples
    // on the leading edge, CPHA=1 on the trailing edge. Both cases reduce to
    // "sample on rising when CPOL equals CPHA".
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return ((cpol != 0) == (cpha != 0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_sync
// Description : Synchronizes sclk, cs_n and mosi into the clk domain and
//               derives single-cycle strobes from the synchronized signals.
// Ports       : clk, rst_n        - system clock, async active-low reset
//               sclk, cs_n, mosi  - raw SPI pins
//               sample_stb        - sclk edge on which mosi is captured
//               shift_stb         - opposite sclk edge, advances miso
//               cs_fall, cs_rise  - synchronized chip-select edges
//               mosi_s            - synchronized mosi, aligned with sample_stb
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync
    import spi_pkg::*;
#(
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sample_stb,
    output logic shift_stb,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    localparam logic c_sclk_idle   = (CPOL != 0);
    localparam logic c_sample_rise = sample_on_rise(CPOL, CPHA);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic w_sclk;
    logic w_cs;
    logic w_rise;
    logic w_fall;

    // The cs_n chain resets low so that a frame already in progress when
    // reset is released does not produce a cs_fall; only a genuine
    // high-to-low transition seen after reset starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{c_sclk_idle}};
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= c_sclk_idle;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_d;
    assign w_fall = ~w_sclk & r_sclk_d;

    assign sample_stb = c_sample_rise ? w_rise : w_fall;
    assign shift_stb  = c_sample_rise ? w_fall : w_rise;
    assign cs_fall    = ~w_cs & r_cs_d;
    assign cs_rise    = w_cs & ~r_cs_d;
    // mosi goes through the same depth as sclk, so at sample_stb this is
    // the value present on the pin at the sclk edge.
    assign mosi_s     = r_mosi_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_reg_bridge
// Description : Oversampling SPI slave that converts command/data frames into
//               single-cycle register bus accesses.
//               Frame: word0 = {R/nW, addr}, word1 = data (MSB first).
//               Optional macro SPI_BRIDGE_AUTO_INC_EN: the DATA phase repeats
//               with the address incrementing after every word (burst).
// Ports       : clk, rst_n                - system clock, async active-low
//               sclk, cs_n, mosi          - SPI inputs
//               miso, miso_oe             - SPI output and pad enable
//               reg_addr, reg_wdata       - register bus address / write data
//               reg_wr, reg_rd            - one-cycle access strobes
//               reg_rdata                 - read data, valid 1 clk after reg_rd
//               busy                      - high for the duration of a frame
//               frame_err                 - one-cycle pulse on a short frame
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_reg_bridge
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [DATA_WIDTH-2:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int              c_aw       = DATA_WIDTH - 1;
    localparam int              c_cw       = $clog2(DATA_WIDTH);
    localparam logic [c_cw-1:0] c_last_bit = c_cw'(DATA_WIDTH - 1);
    localparam int              c_rw_bit   = DATA_WIDTH - 1 - c_rw_bit_from_msb;
    localparam logic            c_cpha0    = (CPHA == 0);

    logic w_sample_stb;
    logic w_shift_stb;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_mosi;

    spi_edge_sync #(
        .CPOL        (CPOL),
        .CPHA        (CPHA),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .sample_stb (w_sample_stb),
        .shift_stb  (w_shift_stb),
        .cs_fall    (w_cs_fall),
        .cs_rise    (w_cs_rise),
        .mosi_s     (w_mosi)
    );

    spi_state_t             r_state;
    logic [c_cw-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-2:0]  r_rx;         // bits received so far in this word
    logic [DATA_WIDTH-1:0]  r_tx;         // bits still to be driven on miso
    logic                   r_miso;
    logic                   r_active;
    logic                   r_is_read;
    logic                   r_rd_d1;      // reg_rdata is valid while this is high
    logic                   r_skip_shift; // swallow the shift edge that follows a load
    logic [c_aw-1:0]        r_reg_addr;
    logic [DATA_WIDTH-1:0]  r_reg_wdata;
    logic                   r_reg_wr;
    logic                   r_reg_rd;
    logic                   r_frame_err;
`ifdef SPI_BRIDGE_AUTO_INC_EN
    logic                   r_first_pend; // next read return feeds TX directly
    logic                   r_word_done;  // at least one data word completed
    logic [DATA_WIDTH-1:0]  r_prefetch;   // read data for the following word
`endif

    logic [DATA_WIDTH-1:0]  w_word;
    logic                   w_word_end;
    logic                   w_short_frame;

    assign w_word     = {r_rx, w_mosi};
    assign w_word_end = w_sample_stb && (r_bit_cnt == c_last_bit);

`ifdef SPI_BRIDGE_AUTO_INC_EN
    assign w_short_frame = (r_state == CMD) ||
                           ((r_state == DATA) && !(r_word_done && (r_bit_cnt == '0)));
`else
    assign w_short_frame = (r_state == CMD) || (r_state == DATA);
`endif

    // With CPHA=0 the MSB must already be on miso before the first leading
    // edge, so a load drives it immediately and keeps the remaining bits.
    // With CPHA=1 the first shift edge (leading) drives the MSB.
    function automatic logic [DATA_WIDTH-1:0] tx_load(input logic [DATA_WIDTH-1:0] d);
        return c_cpha0 ? (d << 1) : d;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_rx         <= '0;
            r_tx         <= '0;
            r_miso       <= 1'b0;
            r_active     <= 1'b0;
            r_is_read    <= 1'b0;
            r_rd_d1      <= 1'b0;
            r_skip_shift <= 1'b0;
            r_reg_addr   <= '0;
            r_reg_wdata  <= '0;
            r_reg_wr     <= 1'b0;
            r_reg_rd     <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef SPI_BRIDGE_AUTO_INC_EN
            r_first_pend <= 1'b0;
            r_word_done  <= 1'b0;
            r_prefetch   <= '0;
`endif
        end else begin
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_frame_err <= 1'b0;
            r_rd_d1     <= r_reg_rd;

            if (w_cs_rise) begin
                // End of frame from any state; a partial word is dropped.
                r_frame_err  <= w_short_frame;
                r_state      <= IDLE;
                r_active     <= 1'b0;
                r_bit_cnt    <= '0;
                r_rx         <= '0;
                r_tx         <= '0;
                r_miso       <= 1'b0;
                r_skip_shift <= 1'b0;
                r_rd_d1      <= 1'b0;
`ifdef SPI_BRIDGE_AUTO_INC_EN
                r_first_pend <= 1'b0;
                r_word_done  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= CMD;
                            r_active  <= 1'b1;
                            r_bit_cnt <= '0;
                        end
                    end

                    CMD: begin
                        if (w_sample_stb) begin
                            r_rx <= w_word[DATA_WIDTH-2:0];
                            if (w_word_end) begin
                                r_bit_cnt    <= '0;
                                r_state      <= DATA;
                                r_reg_addr   <= w_word[c_aw-1:0];
                                r_is_read    <= w_word[c_rw_bit];
                                r_reg_rd     <= w_word[c_rw_bit];
                                // The trailing edge of the last command bit
                                // would otherwise shift out the freshly
                                // loaded MSB in CPHA=0.
                                r_skip_shift <= c_cpha0 & w_word[c_rw_bit];
`ifdef SPI_BRIDGE_AUTO_INC_EN
                                r_first_pend <= w_word[c_rw_bit];
                                r_word_done  <= 1'b0;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end

                    DATA: begin
`ifdef SPI_BRIDGE_AUTO_INC_EN
                        // Write burst: step the address once the strobe
                        // for the current word has been presented.
                        if (r_reg_wr) begin
                            r_reg_addr <= r_reg_addr + 1'b1;
                        end
`endif
                        if (w_shift_stb) begin
                            if (r_skip_shift) begin
                                r_skip_shift <= 1'b0;
                            end else begin
                                r_miso <= r_tx[DATA_WIDTH-1];
                                r_tx   <= r_tx << 1;
                            end
                        end

                        if (r_rd_d1) begin
`ifdef SPI_BRIDGE_AUTO_INC_EN
                            if (r_first_pend) begin
                                r_tx         <= tx_load(reg_rdata);
                                r_miso       <= c_cpha0 ? reg_rdata[DATA_WIDTH-1] : r_miso;
                                r_first_pend <= 1'b0;
                                r_reg_addr   <= r_reg_addr + 1'b1;
                                r_reg_rd     <= 1'b1;
                            end else begin
                                r_prefetch <= reg_rdata;
                            end
`else
                            r_tx   <= tx_load(reg_rdata);
                            r_miso <= c_cpha0 ? reg_rdata[DATA_WIDTH-1] : r_miso;
`endif
                        end

                        if (w_sample_stb) begin
                            r_rx <= w_word[DATA_WIDTH-2:0];
                            if (w_word_end) begin
                                r_bit_cnt <= '0;
                                if (!r_is_read) begin
                                    r_reg_wdata <= w_word;
                                    r_reg_wr    <= 1'b1;
                                end
`ifdef SPI_BRIDGE_AUTO_INC_EN
                                r_word_done <= 1'b1;
                                if (r_is_read) begin
                                    r_tx         <= tx_load(r_prefetch);
                                    r_miso       <= c_cpha0 ? r_prefetch[DATA_WIDTH-1] : r_miso;
                                    r_skip_shift <= c_cpha0;
                                    r_reg_addr   <= r_reg_addr + 1'b1;
                                    r_reg_rd     <= 1'b1;
                                end
`else
                                r_state <= DONE;
                                r_tx    <= '0;
                                r_miso  <= 1'b0;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end

                    DONE: begin
                        // Trailing words are ignored until cs_n rises.
                    end

                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign miso      = r_miso;
    assign miso_oe   = r_active;
    assign busy      = r_active;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_wr    = r_reg_wr;
    assign reg_rd    = r_reg_rd;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_reg_bridge
// Description : Bench for spi_slave_reg_bridge. One DUT per SPI mode
//               (index = {CPOL, CPHA}); an SPI master task drives frames,
//               expected bus events go into a queue that a monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_reg_bridge;

    localparam int c_half = 6;   // sclk half period in clk cycles
    localparam int K_WR   = 0;
    localparam int K_RD   = 1;
    localparam int K_ERR  = 2;

    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] kind;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] sclk_a;
    logic [3:0] cs_a;
    logic       mosi;

    logic       miso_w  [4];
    logic       oe_w    [4];
    logic [6:0] addr_w  [4];
    logic [7:0] wdata_w [4];
    logic       wr_w    [4];
    logic       rd_w    [4];
    logic [7:0] rdata_w [4];
    logic       busy_w  [4];
    logic       err_w   [4];

    logic [7:0] mem [4][128];

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_mode
        spi_slave_reg_bridge #(
            .DATA_WIDTH  (8),
            .CPOL        (gi / 2),
            .CPHA        (gi % 2),
            .SYNC_STAGES (2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .sclk      (sclk_a[gi]),
            .cs_n      (cs_a[gi]),
            .mosi      (mosi),
            .miso      (miso_w[gi]),
            .miso_oe   (oe_w[gi]),
            .reg_addr  (addr_w[gi]),
            .reg_wdata (wdata_w[gi]),
            .reg_wr    (wr_w[gi]),
            .reg_rd    (rd_w[gi]),
            .reg_rdata (rdata_w[gi]),
            .busy      (busy_w[gi]),
            .frame_err (err_w[gi])
        );

        // Register file read port: data one clk after reg_rd.
        always @(posedge clk) begin
            if (rd_w[gi]) rdata_w[gi] <= mem[gi][addr_w[gi]];
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int m, input int k, input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        e.mode = m[1:0];
        e.kind = k[1:0];
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int m, input int k, input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL bus_event: got mode %0d kind %0d addr %h data %h, expected no event",
                     m, k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.mode != m[1:0] || e.kind != k[1:0] || e.addr != a || e.data != d) begin
                n_bad++;
                $display("FAIL bus_event: got mode %0d kind %0d addr %h data %h, expected mode %0d kind %0d addr %h data %h",
                         m, k, a, d, e.mode, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every strobe or error pulse consumes one expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 4; m++) begin
                if (wr_w[m])  check_ev(m, K_WR, addr_w[m], wdata_w[m]);
                if (rd_w[m])  check_ev(m, K_RD, addr_w[m], 8'h00);
                if (err_w[m]) check_ev(m, K_ERR, 7'h00, 8'h00);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SPI master: shifts nbits of tx (MSB first from bit 23), returns the
    // bits seen on miso in the same positions.
    task automatic spi_frame(input int m, input int nbits, input logic [23:0] tx,
                             input bit raise_cs, output logic [23:0] rx);
        logic cpol;
        logic cpha;
        cpol = (m / 2) != 0;
        cpha = (m % 2) != 0;
        rx   = '0;
        @(negedge clk);
        cs_a[m] = 1'b0;
        wait_clk(c_half);
        cmp($sformatf("busy_in_frame_m%0d", m), {oe_w[m], busy_w[m]}, 2'b11);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = tx[23-i];
                wait_clk(c_half);
                sclk_a[m]  = ~cpol;
                rx[23-i]   = miso_w[m];
                wait_clk(c_half);
                sclk_a[m]  = cpol;
            end else begin
                sclk_a[m]  = ~cpol;
                mosi       = tx[23-i];
                wait_clk(c_half);
                sclk_a[m]  = cpol;
                rx[23-i]   = miso_w[m];
                wait_clk(c_half);
            end
        end
        if (raise_cs) begin
            wait_clk(c_half);
            cs_a[m] = 1'b1;
            wait_clk(3 * c_half);
            cmp($sformatf("busy_after_frame_m%0d", m), {oe_w[m], busy_w[m]}, 2'b00);
        end
    endtask

    function automatic logic [20:0] outs(input int m);
        return {miso_w[m], oe_w[m], addr_w[m], wdata_w[m], wr_w[m], rd_w[m], busy_w[m], err_w[m]};
    endfunction

    initial begin
        logic [23:0] rx;
        rst_n  = 1'b0;
        cs_a   = 4'hF;
        sclk_a = 4'b1100;
        mosi   = 1'b0;
        for (int m = 0; m < 4; m++) begin
            for (int a = 0; a < 128; a++) mem[m][a] = 8'h00;
            mem[m][7'h12] = 8'h3C;
        end
        mem[0][7'h20] = 8'hC3;
        mem[0][7'h21] = 8'h5A;
        for (int m = 0; m < 4; m++) rdata_w[m] = 8'h00;

        wait_clk(4);
        for (int m = 0; m < 4; m++) cmp($sformatf("reset_outputs_m%0d", m), outs(m), 0);
        rst_n = 1'b1;
        wait_clk(10);

        // Write and read in every mode.
        for (int m = 0; m < 4; m++) begin
            expect_ev(m, K_WR, 7'h05, 8'hA5);
            spi_frame(m, 16, 24'h05A500, 1'b1, rx);
            cmp($sformatf("write_miso_m%0d", m), rx[23:8], 16'h0000);

            expect_ev(m, K_RD, 7'h12, 8'h00);
            spi_frame(m, 16, 24'h920000, 1'b1, rx);
            cmp($sformatf("read_cmd_miso_m%0d", m), rx[23:16], 8'h00);
            cmp($sformatf("read_data_m%0d", m), rx[15:8], 8'h3C);
        end

        // Abort after 4 data bits, then a clean write.
        expect_ev(0, K_ERR, 7'h00, 8'h00);
        spi_frame(0, 12, 24'h05A500, 1'b1, rx);
        expect_ev(0, K_WR, 7'h06, 8'h11);
        spi_frame(0, 16, 24'h061100, 1'b1, rx);

        // Abort inside the command byte (mode 3).
        expect_ev(3, K_ERR, 7'h00, 8'h00);
        spi_frame(3, 3, 24'h050000, 1'b1, rx);

`ifdef SPI_BRIDGE_AUTO_INC_EN
        // Write burst wrapping the address 0x7F -> 0x00.
        expect_ev(0, K_WR, 7'h7F, 8'h01);
        expect_ev(0, K_WR, 7'h00, 8'h02);
        spi_frame(0, 24, 24'h7F0102, 1'b1, rx);
        // Read burst of two words; each load prefetches the next address.
        expect_ev(0, K_RD, 7'h20, 8'h00);
        expect_ev(0, K_RD, 7'h21, 8'h00);
        expect_ev(0, K_RD, 7'h22, 8'h00);
        expect_ev(0, K_RD, 7'h23, 8'h00);
        spi_frame(0, 24, 24'hA00000, 1'b1, rx);
        cmp("burst_read_word0", rx[15:8], 8'hC3);
        cmp("burst_read_word1", rx[7:0], 8'h5A);
`else
        // Extra byte after the data word is ignored.
        expect_ev(0, K_WR, 7'h05, 8'hA5);
        spi_frame(0, 24, 24'h05A533, 1'b1, rx);
        cmp("extra_byte_miso", rx, 24'h000000);
`endif

        // Reset in the middle of a read data byte.
        expect_ev(0, K_RD, 7'h12, 8'h00);
        spi_frame(0, 12, 24'h920000, 1'b0, rx);
        #2 rst_n = 1'b0;
        #1 cmp("reset_mid_read", outs(0), 0);
        wait_clk(3);
        cs_a[0] = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(10);
        cmp("after_reset_outputs", outs(0), 0);
        expect_ev(0, K_WR, 7'h2A, 8'h77);
        spi_frame(0, 16, 24'h2A7700, 1'b1, rx);

        wait_clk(20);
        cmp("events_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d events outstanding", exp_q.size());
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_reg_bridge.md
Name: spi_slave_reg_bridge

Overview:
SPI responder that turns frames from the team's SPI master into register accesses on a simple parallel bus. It oversamples sclk/cs_n/mosi in the system clock domain, so it is the far-end peer of the master. It decodes a command byte, then writes or reads one data word (more with burst enabled). It sits between the SPI pins and a register file / CSR block.

Parameters:
data_width, 8, bits per SPI word; address width is data_width-1
CPOL, 0, idle level of sclk (0 or 1)
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/mosi (>=2)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from master
cs_n  input  1  chip select, active low
mosi  input  1  master-out data, MSB first
miso  output  1  slave-out data, MSB first
miso_oe  output  1  1 while cs_n (synchronized) low; pad tristate enable
reg_addr  output  data_width-1  register address
reg_wdata  output  data_width  write data
reg_wr  output  1  one-cycle write strobe
reg_rd  output  1  one-cycle read strobe
reg_rdata  input  data_width  read data, valid exactly 1 clk after reg_rd
busy  output  1  1 from cs_n fall to cs_n rise (synchronized)
frame_err  output  1  one-cycle pulse on aborted/short frame

Behaviour:
- Reset values: miso=0, miso_oe=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, frame_err=0, state=IDLE.
- Constraint: sclk frequency <= clk/10 (50 MHz / 5 MHz in the system). Faster is unsupported.
- Sync: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edge detect on synced sclk gives the sample strobe (CPOL/CPHA-selected edge) and the shift strobe (the opposite edge).
- Frame: byte0 = command, bit[data_width-1] = R/nW (1 = read), bits[data_width-2:0] = address. Byte1 = data.
- States: IDLE -> CMD on synced cs_n fall. CMD -> DATA after data_width sample strobes. DATA -> DONE after data_width sample strobes. DONE -> IDLE on cs_n rise. Any state -> IDLE on cs_n rise.
- CMD complete, read: reg_addr latched and reg_rd pulses on the next clk. reg_rdata is loaded into the TX shift register the clk after that.
- CMD complete, write: reg_addr latched. No strobe yet.
- DATA complete, write: reg_wdata = assembled word; reg_wr pulses on the next clk.
- MISO during CMD and during a write DATA phase: 0.
- MISO during a read DATA phase: MSB first.
  - CPHA=0: MSB is driven right after the load, before the first leading edge, and shifts on each shift strobe.
  - CPHA=1: each bit is driven on the leading edge.
- cs_n rise before DATA completes: frame_err pulses 1 clk, no reg_wr, shift counters cleared. A partially received word is discarded.
- cs_n rise in IDLE: no frame_err.
- Bytes after DATA completes with AUTO_INC_EN absent: ignored, no strobes, miso=0, no frame_err.
- A new cs_n fall during the DONE->IDLE transition is honoured on the following clk.
- rst_n assertion mid-frame forces reset values immediately. The frame is lost without frame_err.

Optional Feature:
SPI_BRIDGE_AUTO_INC_EN
- Defined: after each DATA word, state stays in DATA and reg_addr increments, wrapping 2^(data_width-1)-1 -> 0.
  - Write burst: reg_wr once per completed word.
  - Read burst: reg_rd for the next address is issued on the same clk the current word is loaded into the TX shift register.
  - A partial trailing word raises frame_err; completed words stand.
- Not defined: single access per frame, as above.

Decomposition:
- Package spi_pkg: state enum (IDLE, CMD, DATA, DONE), RW_BIT position constant, and a function computing the sample-edge select from CPOL/CPHA.
- Sub-module spi_edge_sync: synchronizers plus edge detect. Outputs sample_stb, shift_stb, cs_fall, cs_rise and the synced mosi.

Test Plan:
- Write: mode 0, frame 0x05, 0xA5 -> one reg_wr with reg_addr=0x05 and reg_wdata=0xA5. frame_err stays 0.
- Read: reg file holds 0x3C at 0x12, frame 0x92, 0x00 -> one reg_rd with addr 0x12. Master receives 0x3C.
- Modes: repeat the write and read in all four CPOL/CPHA combinations -> identical bus activity. Master data matches each time.
- Abort: cs_n raised after 4 bits of the data byte of a 0x05 write -> frame_err single pulse, no reg_wr. The next frame (0x06, 0x11) writes correctly.
- Reset mid-read: rst_n low during DATA -> all outputs at reset values within 1 clk. The following frame succeeds.
- AUTO_INC (macro on): write frame 0x7F, 0x01, 0x02 -> reg_wr to 0x7F (0x01) then to 0x00 (0x02).
